// File: rtl/cora16_spi_pkg.sv
// Shared SPI memory protocol definitions for the cora16 SPI master and the SPI RAM target.
package cora16_spi_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         SPI_ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the SPI pins into the clk domain and detects spi_clk and select edges.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_spi_clk,
    input  logic i_spi_select,
    input  logic i_spi_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_sel,
    output logic o_sel_rise,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_sel_prev;
    logic                   w_sclk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_sel_sync  <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_sel_prev  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], i_spi_select};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sclk_prev <= w_sclk;
            r_sel_prev  <= o_sel;
        end
    end

    // mosi goes through the same depth as spi_clk so a detected rise lines up with its data bit
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign o_sel       = r_sel_sync[SYNC_STAGES-1];
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign o_sclk_rise = w_sclk & ~r_sclk_prev;
    assign o_sclk_fall = ~w_sclk & r_sclk_prev;
    assign o_sel_rise  = o_sel & ~r_sel_prev;

endmodule

// File: rtl/spi_mem_target.sv
// SPI RAM target (23LC-style READ/WRITE, mode 0, MSB first, 24-bit address, sequential mode).
//
// state  | meaning
// IDLE   | waiting for select rise
// CMD    | shifting in the command byte
// ADDR   | shifting in 3 address bytes
// RD     | streaming mem bytes out on miso, address auto-increments
// WR     | assembling bytes from mosi and committing each full byte
// IGNORE | unknown command, miso held 0 until deselect
import cora16_spi_pkg::*;

module spi_mem_target #(
    parameter int    DEPTH       = 256,
    parameter string INIT_FILE   = "",
    parameter int    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  spi_select,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  active,
    output logic                  wr_pulse,
    input  logic [SPI_ADDR_W-1:0] debug_addr,
    output logic [31:0]           debug_data
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    spi_state_t    r_state;
    spi_state_t    w_next;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rd_shift;
    logic [AW-1:0] r_addr;
    logic          r_is_read;
    logic          r_miso;
    logic          r_wr_pulse;
    logic [31:0]   r_debug_data;

    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_sel;
    logic          w_sel_rise;
    logic          w_mosi;
    logic          w_byte_done;
    logic          w_mem_we;
    logic [7:0]    w_shift_in;
    logic [AW-1:0] w_addr_in;
    logic [AW-1:0] w_addr_inc;
    logic [AW-1:0] w_dbg_a0;
    logic          w_unused;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_spi_clk   (spi_clk),
        .i_spi_select(spi_select),
        .i_spi_mosi  (spi_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_sel       (w_sel),
        .o_sel_rise  (w_sel_rise),
        .o_mosi      (w_mosi)
    );

    // Only the low AW address bits are kept, so upper address bits alias by construction
    assign w_shift_in  = {r_shift[6:0], w_mosi};
    assign w_addr_in   = {r_addr[AW-2:0], w_mosi};
    assign w_addr_inc  = r_addr + AW'(1);
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_mem_we    = w_sel && (r_state == WR) && w_byte_done;
    assign w_dbg_a0    = debug_addr[AW-1:0];
    assign w_unused    = ^debug_addr[SPI_ADDR_W-1:AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!w_sel) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_sel_rise) w_next = CMD;
                CMD: begin
                    if (w_byte_done) begin
                        if (w_shift_in == CMD_READ || w_shift_in == CMD_WRITE) w_next = ADDR;
                        else                                                   w_next = IGNORE;
                    end
                end
                ADDR: if (w_byte_done && r_byte_idx == 2'd2) w_next = r_is_read ? RD : WR;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_rd_shift <= '0;
            r_addr     <= '0;
            r_is_read  <= 1'b0;
            r_miso     <= 1'b0;
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (!w_sel || r_state == IDLE) begin
                r_miso     <= 1'b0;
                r_bit_cnt  <= '0;
                r_byte_idx <= '0;
            end else begin
                if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
                case (r_state)
                    CMD: begin
                        if (w_sclk_rise) r_shift <= w_shift_in;
                        if (w_byte_done) r_is_read <= (w_shift_in == CMD_READ);
                    end
                    ADDR: begin
                        if (w_sclk_rise) r_addr <= w_addr_in;
                        if (w_byte_done) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (r_byte_idx == 2'd2) r_rd_shift <= r_mem[w_addr_in];
                        end
                    end
                    RD: begin
                        if (w_sclk_fall) begin
                            r_miso     <= r_rd_shift[7];
                            r_rd_shift <= {r_rd_shift[6:0], 1'b0};
                        end else if (w_byte_done) begin
                            r_addr     <= w_addr_inc;
                            r_rd_shift <= r_mem[w_addr_inc];
                        end
                    end
                    WR: begin
                        if (w_sclk_rise) r_shift <= w_shift_in;
                        if (w_byte_done) begin
                            r_wr_pulse <= 1'b1;
                            r_addr     <= w_addr_inc;
                        end
                    end
                    default: r_miso <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_addr] <= w_shift_in;
    end

    // Reads the array before this clk's write lands, so a colliding write shows the old byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_debug_data <= '0;
        end else begin
            r_debug_data <= {r_mem[w_dbg_a0],          r_mem[w_dbg_a0 + AW'(1)],
                             r_mem[w_dbg_a0 + AW'(2)], r_mem[w_dbg_a0 + AW'(3)]};
        end
    end

    assign spi_miso   = r_miso;
    assign active     = (r_state != IDLE);
    assign wr_pulse   = r_wr_pulse;
    assign debug_data = r_debug_data;

endmodule

// File: tb/tb_spi_mem_target.sv
// Directed bench for spi_mem_target: SPI master driver plus scoreboard monitors on miso and wr_pulse.
module tb_spi_mem_target;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_select;
    logic        spi_mosi;
    logic        spi_miso;
    logic        active;
    logic        wr_pulse;
    logic [23:0] debug_addr;
    logic [31:0] debug_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_wr[$];
    logic        mon_rd = 1'b0;
    logic [7:0]  mon_sh = 8'h00;
    int          mon_n  = 0;

    spi_mem_target #(
        .DEPTH      (256),
        .INIT_FILE  (""),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_select(spi_select),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .active    (active),
        .wr_pulse  (wr_pulse),
        .debug_addr(debug_addr),
        .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    // miso monitor: master samples on each spi_clk rise while a data phase is open
    always @(posedge spi_clk) begin
        if (mon_rd) begin
            mon_sh = {mon_sh[6:0], spi_miso};
            mon_n  = mon_n + 1;
            if (mon_n == 8) begin
                mon_n   = 0;
                n_tests = n_tests + 1;
                if (exp_rd.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL miso_byte: got %h with no byte expected", mon_sh);
                end else begin
                    logic [7:0] e;
                    e = exp_rd.pop_front();
                    if (mon_sh !== e) begin
                        n_fail = n_fail + 1;
                        $display("FAIL miso_byte: got %h expected %h", mon_sh, e);
                    end
                end
            end
        end else begin
            mon_n = 0;
        end
    end

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            n_tests = n_tests + 1;
            if (exp_wr.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL wr_pulse: got pulse expected none");
            end else begin
                void'(exp_wr.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nb);
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = b[i];
            #HALF spi_clk = 1'b1;
            #HALF spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        xfer_bits(b, 8);
    endtask

    task automatic sel_open();
        spi_select = 1'b1;
        #HALF;
    endtask

    task automatic sel_close();
        #HALF;
        spi_mosi   = 1'b0;
        spi_select = 1'b0;
        #(2*HALF);
    endtask

    task automatic dbg_check(input string name, input logic [23:0] a,
                             input logic [31:0] exp, input logic [31:0] mask);
        debug_addr = a;
        #30;
        check(name, debug_data & mask, exp & mask);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        spi_clk    = 1'b0;
        spi_select = 1'b0;
        spi_mosi   = 1'b0;
        debug_addr = 24'h0;
        #23;
        check("reset_miso", {31'b0, spi_miso}, 32'd0);
        check("reset_active", {31'b0, active}, 32'd0);
        check("reset_wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("reset_debug", debug_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #40;

        // write DE AD BE EF at 0x10
        sel_open();
        xfer(8'h02); xfer(8'h00); xfer(8'h00); xfer(8'h10);
        exp_wr.push_back(8'hDE); exp_wr.push_back(8'hAD);
        exp_wr.push_back(8'hBE); exp_wr.push_back(8'hEF);
        check("active_in_write", {31'b0, active}, 32'd1);
        xfer(8'hDE); xfer(8'hAD); xfer(8'hBE); xfer(8'hEF);
        sel_close();
        check("wr_pulses_4", exp_wr.size(), 32'd0);
        check("idle_after_deselect", {31'b0, active}, 32'd0);
        dbg_check("debug_10", 24'h000010, 32'hDEADBEEF, 32'hFFFFFFFF);
        dbg_check("debug_alias", 24'hAB0010, 32'hDEADBEEF, 32'hFFFFFFFF);

        // sequential read from 0x11
        sel_open();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h11);
        exp_rd.push_back(8'hAD); exp_rd.push_back(8'hBE); exp_rd.push_back(8'hEF);
        mon_rd = 1'b1;
        xfer(8'h00); xfer(8'h00); xfer(8'h00);
        mon_rd = 1'b0;
        sel_close();
        check("rd_drained_11", exp_rd.size(), 32'd0);

        // write across the DEPTH boundary, then read back via an aliased address
        sel_open();
        xfer(8'h02); xfer(8'h00); xfer(8'h00); xfer(8'hFF);
        exp_wr.push_back(8'h11); exp_wr.push_back(8'h22);
        xfer(8'h11); xfer(8'h22);
        sel_close();
        check("wr_pulses_wrap", exp_wr.size(), 32'd0);
        dbg_check("debug_ff_wrap", 24'h0000FF, 32'h11220000, 32'hFFFF0000);
        sel_open();
        xfer(8'h03); xfer(8'h00); xfer(8'h01); xfer(8'hFF);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        mon_rd = 1'b1;
        xfer(8'h00); xfer(8'h00);
        mon_rd = 1'b0;
        sel_close();
        check("rd_drained_wrap", exp_rd.size(), 32'd0);

        // unknown command: miso stays 0, nothing written
        sel_open();
        xfer(8'h05);
        exp_rd.push_back(8'h00); exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
        mon_rd = 1'b1;
        xfer(8'h00); xfer(8'h00); xfer(8'h10);
        mon_rd = 1'b0;
        check("active_in_ignore", {31'b0, active}, 32'd1);
        sel_close();
        check("rd_drained_ignore", exp_rd.size(), 32'd0);
        dbg_check("debug_after_ignore", 24'h000010, 32'hDEADBEEF, 32'hFFFFFFFF);

        // partial trailing byte is dropped
        sel_open();
        xfer(8'h02); xfer(8'h00); xfer(8'h00); xfer(8'h21);
        exp_wr.push_back(8'h55);
        xfer(8'h55);
        sel_close();
        sel_open();
        xfer(8'h02); xfer(8'h00); xfer(8'h00); xfer(8'h20);
        exp_wr.push_back(8'hAB);
        xfer(8'hAB);
        xfer_bits(8'hFF, 4);
        sel_close();
        check("wr_pulses_partial", exp_wr.size(), 32'd0);
        dbg_check("debug_partial", 24'h000020, 32'hAB550000, 32'hFFFF0000);

        // reset in the middle of a read
        debug_addr = 24'h000010;
        sel_open();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h10);
        #HALF;
        check("pre_rst_miso_msb", {31'b0, spi_miso}, 32'd1);
        check("pre_rst_active", {31'b0, active}, 32'd1);
        check("pre_rst_debug", debug_data, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_miso", {31'b0, spi_miso}, 32'd0);
        check("rst_mid_active", {31'b0, active}, 32'd0);
        check("rst_mid_debug", debug_data, 32'd0);
        #7 spi_select = 1'b0;
        #20 rst = 1'b0;
        #(2*HALF);
        dbg_check("mem_kept_after_rst", 24'h000010, 32'hDEADBEEF, 32'hFFFFFFFF);

        // fresh read after reselect
        sel_open();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h10);
        exp_rd.push_back(8'hDE); exp_rd.push_back(8'hAD);
        mon_rd = 1'b1;
        xfer(8'h00); xfer(8'h00);
        mon_rd = 1'b0;
        sel_close();
        check("rd_drained_after_rst", exp_rd.size(), 32'd0);
        check("no_stray_wr", exp_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
